// File: rtl/vertex_averager.sv
// Sequential K-point averager: reads groups of signed words from a source RAM and
// writes one average per group (truncated toward zero) to a destination RAM.
module vertex_averager #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned MAX_GROUP = 8,
    parameter int unsigned GRP_W     = $clog2(MAX_GROUP + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   src_base,
    input  logic [ADDR_W-1:0]   dst_base,
    input  logic [ADDR_W:0]     len,
    input  logic [GRP_W-1:0]    group,
    output logic                src_en,
    output logic [ADDR_W-1:0]   src_a,
    input  logic [DATA_W-1:0]   src_do,
    output logic                dst_en,
    output logic [DATA_W/8-1:0] dst_we,
    output logic [ADDR_W-1:0]   dst_a,
    output logic [DATA_W-1:0]   dst_di,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam int unsigned ACC_W = DATA_W + GRP_W;
    localparam int unsigned CNT_W = $clog2(ACC_W);
    localparam int unsigned LEN_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DIV,
        S_WRITE,
        S_FIN
    } state_t;

    state_t                  state;
    logic [ADDR_W-1:0]       src_ptr;
    logic [ADDR_W-1:0]       dst_ptr;
    logic [LEN_W-1:0]        rem_len;
    logic [GRP_W-1:0]        grp;
    logic [GRP_W-1:0]        rd_left;
    logic                    rd_vld;
    logic signed [ACC_W-1:0] acc;
    logic [ACC_W-1:0]        divq;
    logic [GRP_W-1:0]        divr;
    logic                    neg;
    logic [CNT_W-1:0]        dcnt;

    logic signed [ACC_W-1:0] acc_nxt_c;
    logic [ACC_W-1:0]        mag_c;
    logic                    grp_ok_c;
    logic                    more_c;
    logic                    pow2_c;
    logic [GRP_W-1:0]        shift_c;
    logic [GRP_W:0]          rsh_c;
    logic [GRP_W:0]          rsub_c;
    logic                    ge_c;
    logic [ACC_W-1:0]        quo_c;
    logic [DATA_W-1:0]       res_c;

    // Accumulate, magnitude split, and one restoring-divide step (or a power-of-two shift).
    always_comb begin
        acc_nxt_c = acc;
        if (rd_vld) acc_nxt_c = acc + ACC_W'($signed(src_do));
        mag_c    = acc_nxt_c[ACC_W-1] ? ACC_W'(-acc_nxt_c) : ACC_W'(acc_nxt_c);
        grp_ok_c = (group != '0) && (32'(group) <= MAX_GROUP);
        more_c   = rem_len >= LEN_W'(grp);
        pow2_c   = (grp & (grp - GRP_W'(1))) == '0;
        shift_c  = '0;
        for (int unsigned i = 0; i < GRP_W; i++) begin
            if (grp[i]) shift_c = GRP_W'(i);
        end
        rsh_c  = {divr, divq[ACC_W-1]};
        rsub_c = rsh_c - {1'b0, grp};
        ge_c   = ~rsub_c[GRP_W];
        quo_c  = pow2_c ? (divq >> shift_c) : {divq[ACC_W-2:0], ge_c};
        res_c  = neg ? DATA_W'(-quo_c) : DATA_W'(quo_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            src_ptr <= '0;
            dst_ptr <= '0;
            rem_len <= '0;
            grp     <= '0;
            rd_left <= '0;
            rd_vld  <= 1'b0;
            acc     <= '0;
            divq    <= '0;
            divr    <= '0;
            neg     <= 1'b0;
            dcnt    <= '0;
            src_en  <= 1'b0;
            src_a   <= '0;
            dst_en  <= 1'b0;
            dst_we  <= '0;
            dst_a   <= '0;
            dst_di  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            rd_vld <= src_en;
            acc    <= acc_nxt_c;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (!grp_ok_c) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            err     <= 1'b0;
                            grp     <= group;
                            dst_ptr <= dst_base;
                            if (len < LEN_W'(group)) begin
                                done  <= 1'b1;
                                state <= S_FIN;
                            end else begin
                                busy    <= 1'b1;
                                src_en  <= 1'b1;
                                src_a   <= src_base;
                                src_ptr <= src_base + ADDR_W'(1);
                                rd_left <= group - GRP_W'(1);
                                rem_len <= len - LEN_W'(group);
                                acc     <= '0;
                                state   <= S_READ;
                            end
                        end
                    end
                end
                S_READ: begin
                    if (rd_left == '0) begin
                        src_en <= 1'b0;
                        state  <= S_DRAIN;
                    end else begin
                        src_a   <= src_ptr;
                        src_ptr <= src_ptr + ADDR_W'(1);
                        rd_left <= rd_left - GRP_W'(1);
                    end
                end
                // Last word lands this cycle; divide operates on the final magnitude.
                S_DRAIN: begin
                    divq  <= mag_c;
                    neg   <= acc_nxt_c[ACC_W-1];
                    divr  <= '0;
                    dcnt  <= '0;
                    state <= S_DIV;
                end
                S_DIV: begin
                    if (pow2_c || (dcnt == CNT_W'(ACC_W - 1))) begin
                        dst_en  <= 1'b1;
                        dst_we  <= '1;
                        dst_a   <= dst_ptr;
                        dst_di  <= res_c;
                        dst_ptr <= dst_ptr + ADDR_W'(1);
                        state   <= S_WRITE;
                    end else begin
                        divq <= quo_c;
                        divr <= ge_c ? rsub_c[GRP_W-1:0] : rsh_c[GRP_W-1:0];
                        dcnt <= dcnt + CNT_W'(1);
                    end
                end
                S_WRITE: begin
                    dst_en <= 1'b0;
                    dst_we <= '0;
                    if (more_c) begin
                        src_en  <= 1'b1;
                        src_a   <= src_ptr;
                        src_ptr <= src_ptr + ADDR_W'(1);
                        rd_left <= grp - GRP_W'(1);
                        rem_len <= rem_len - LEN_W'(grp);
                        acc     <= '0;
                        state   <= S_READ;
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vertex_averager.sv
// Self-checking bench for vertex_averager: RAM models, activity monitor and a
// plain-arithmetic reference model of the group averages.
module tb_vertex_averager;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned GRP_W  = 4;
    localparam int unsigned LEN_W  = ADDR_W + 1;
    localparam int          DEPTH  = 512;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic [ADDR_W-1:0]   src_base = '0;
    logic [ADDR_W-1:0]   dst_base = '0;
    logic [LEN_W-1:0]    len = '0;
    logic [GRP_W-1:0]    group = '0;
    logic                src_en;
    logic [ADDR_W-1:0]   src_a;
    logic [DATA_W-1:0]   src_do;
    logic                dst_en;
    logic [DATA_W/8-1:0] dst_we;
    logic [ADDR_W-1:0]   dst_a;
    logic [DATA_W-1:0]   dst_di;
    logic                busy;
    logic                done;
    logic                err;

    vertex_averager #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_GROUP(8)) dut (
        .clk(clk), .rst(rst), .start(start), .src_base(src_base), .dst_base(dst_base),
        .len(len), .group(group), .src_en(src_en), .src_a(src_a), .src_do(src_do),
        .dst_en(dst_en), .dst_we(dst_we), .dst_a(dst_a), .dst_di(dst_di),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    logic [31:0] src_mem [DEPTH];
    logic [31:0] dst_mem [DEPTH];
    always @(posedge clk) if (src_en) src_do <= src_mem[src_a];
    always @(posedge clk) if (dst_en && dst_we == 4'hF) dst_mem[dst_a] <= dst_di;

    // Activity log, sampled on the falling edge.
    int          rd_q[$];
    int          wr_a[$];
    logic [31:0] wr_d[$];
    int done_cnt = 0, busy_cyc = 0, overlap = 0, badwe = 0;
    always @(negedge clk) begin
        if (src_en) rd_q.push_back(int'(src_a));
        if (dst_en) begin
            wr_a.push_back(int'(dst_a));
            wr_d.push_back(dst_di);
        end
        if (src_en && (dst_en || dst_we != '0)) overlap++;
        if (dst_en && dst_we != 4'hF) badwe++;
        if (done) done_cnt++;
        if (busy) busy_cyc++;
    end

    int checks = 0, failures = 0;
    int rd0, wr0, done0, busy0, ov0, we0;
    int          exp_a[$];
    logic [31:0] exp_d[$];
    int          exp_rd[$];
    int          exp_lat;

    function automatic void build_expect(input int sb, input int db, input int ln, input int g);
        int ng, a;
        longint s;
        exp_a.delete(); exp_d.delete(); exp_rd.delete();
        ng = (g >= 1 && g <= 8) ? ln / g : 0;
        for (int k = 0; k < ng; k++) begin
            s = 0;
            for (int i = 0; i < g; i++) begin
                a = (sb + k * g + i) % DEPTH;
                exp_rd.push_back(a);
                s += longint'($signed(src_mem[a]));
            end
            exp_a.push_back((db + k) % DEPTH);
            exp_d.push_back(32'(s / g));
        end
        exp_lat = ng * (g + 2 + (((g & (g - 1)) == 0) ? 1 : 36));
    endfunction

    task automatic mark();
        rd0 = rd_q.size(); wr0 = wr_a.size(); done0 = done_cnt;
        busy0 = busy_cyc; ov0 = overlap; we0 = badwe;
    endtask

    task automatic run_job(input int sb, input int db, input int ln, input int g, output bit fin);
        build_expect(sb, db, ln, g);
        @(negedge clk);
        mark();
        src_base = ADDR_W'(sb); dst_base = ADDR_W'(db); len = LEN_W'(ln); group = GRP_W'(g);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        fin = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (done) begin fin = 1'b1; break; end
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({src_en, src_a, dst_en, dst_we, dst_a, dst_di, busy, done, err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h required=0",
                     {src_en, src_a, dst_en, dst_we, dst_a, dst_di, busy, done, err});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, err, src_en, dst_en} !== 5'b0) begin
            failures++; $display("FAIL idle_after_reset got=%b required=00000", {busy, done, err, src_en, dst_en});
        end
    endtask

    task automatic test_basic();
        bit fin;
        for (int i = 0; i < 4; i++) src_mem[i] = 32'((i + 1) * 10);
        run_job(0, 100, 4, 4, fin);
        checks++; if (!fin) begin failures++; $display("FAIL basic_timeout got=no_done required=done"); end
        checks++; if (dst_mem[100] !== 32'd25) begin failures++; $display("FAIL basic_avg got=%0d required=25", dst_mem[100]); end
        checks++; if (busy_cyc - busy0 !== 7) begin failures++; $display("FAIL basic_latency got=%0d required=7", busy_cyc - busy0); end
        checks++; if (wr_a.size() - wr0 !== 1) begin failures++; $display("FAIL basic_writes got=%0d required=1", wr_a.size() - wr0); end
        checks++; if (done_cnt - done0 !== 1) begin failures++; $display("FAIL basic_done got=%0d required=1", done_cnt - done0); end
    endtask

    task automatic test_trunc();
        bit fin;
        src_mem[0] = 32'd1; src_mem[1] = 32'd2; src_mem[2] = 32'd4;
        src_mem[3] = -32'sd1; src_mem[4] = -32'sd2; src_mem[5] = -32'sd4;
        run_job(0, 0, 6, 3, fin);
        checks++; if (dst_mem[0] !== 32'd2) begin failures++; $display("FAIL trunc_pos got=%0d required=2", $signed(dst_mem[0])); end
        checks++; if (dst_mem[1] !== 32'hFFFF_FFFE) begin failures++; $display("FAIL trunc_neg got=%0d required=-2", $signed(dst_mem[1])); end
        checks++; if (busy_cyc - busy0 !== 82) begin failures++; $display("FAIL trunc_latency got=%0d required=82", busy_cyc - busy0); end
        checks++; if (wr_a.size() - wr0 !== 2) begin failures++; $display("FAIL trunc_writes got=%0d required=2", wr_a.size() - wr0); end
    endtask

    task automatic test_leftover();
        bit fin;
        int bad;
        for (int i = 0; i < 16; i++) src_mem[i] = $urandom();
        run_job(0, 50, 10, 3, fin);
        checks++; if (wr_a.size() - wr0 !== 3) begin failures++; $display("FAIL left_writes got=%0d required=3", wr_a.size() - wr0); end
        bad = 0;
        for (int i = rd0; i < rd_q.size(); i++) if (rd_q[i] >= 9) bad++;
        checks++; if (bad != 0 || rd_q.size() - rd0 != 9) begin
            failures++; $display("FAIL left_reads got=%0d_reads_%0d_beyond required=9_reads_0_beyond", rd_q.size() - rd0, bad);
        end
        bad = 0;
        for (int k = 0; k < 3; k++) if (wr0 + k >= wr_d.size() || wr_d[wr0 + k] !== exp_d[k]) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL left_data got=%0d_wrong required=0_wrong", bad); end
        checks++; if (done_cnt - done0 !== 1) begin failures++; $display("FAIL left_done got=%0d required=1", done_cnt - done0); end
    endtask

    task automatic test_err();
        bit fin;
        int gs[2] = '{0, 9};
        for (int t = 0; t < 2; t++) begin
            run_job(0, 0, 8, gs[t], fin);
            checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_set_g%0d got=%b required=1", gs[t], err); end
            checks++; if (done_cnt - done0 !== 1) begin failures++; $display("FAIL err_done_g%0d got=%0d required=1", gs[t], done_cnt - done0); end
            checks++; if ((rd_q.size() - rd0) + (wr_a.size() - wr0) + (busy_cyc - busy0) != 0) begin
                failures++; $display("FAIL err_activity_g%0d got=%0d required=0", gs[t], (rd_q.size() - rd0) + (wr_a.size() - wr0) + (busy_cyc - busy0));
            end
        end
        src_mem[0] = 32'd6; src_mem[1] = 32'd8;
        run_job(0, 300, 2, 2, fin);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b required=0", err); end
        checks++; if (dst_mem[300] !== 32'd7) begin failures++; $display("FAIL err_next_avg got=%0d required=7", dst_mem[300]); end
    endtask

    task automatic test_wrap();
        bit fin;
        int er[4] = '{510, 511, 0, 1};
        int ew[2] = '{511, 0};
        int bad;
        src_mem[510] = 32'd100; src_mem[511] = -32'sd50; src_mem[0] = 32'd7; src_mem[1] = 32'd8;
        run_job(510, 511, 4, 2, fin);
        bad = (rd_q.size() - rd0 != 4) ? 1 : 0;
        for (int i = 0; i < 4; i++) if (rd0 + i >= rd_q.size() || rd_q[rd0 + i] != er[i]) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL wrap_reads got=%0d_wrong required=0_wrong", bad); end
        bad = (wr_a.size() - wr0 != 2) ? 1 : 0;
        for (int i = 0; i < 2; i++) if (wr0 + i >= wr_a.size() || wr_a[wr0 + i] != ew[i]) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL wrap_writes got=%0d_wrong required=0_wrong", bad); end
        checks++; if (dst_mem[511] !== 32'd25 || dst_mem[0] !== 32'd7) begin
            failures++; $display("FAIL wrap_data got=%0d,%0d required=25,7", dst_mem[511], dst_mem[0]);
        end
    endtask

    task automatic test_max();
        bit fin;
        logic [31:0] vals[4] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000};
        int          gs[4]   = '{8, 7, 8, 5};
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 8; i++) src_mem[i] = vals[c];
            run_job(0, 400 + c, gs[c], gs[c], fin);
            checks++; if (dst_mem[400 + c] !== vals[c]) begin
                failures++; $display("FAIL max_mag_%0d got=%h required=%h", c, dst_mem[400 + c], vals[c]);
            end
        end
    endtask

    task automatic test_rst_mid();
        bit fin;
        for (int i = 0; i < 6; i++) src_mem[i] = 32'(i * 7 + 3);
        @(negedge clk);
        mark();
        src_base = '0; dst_base = 9'd200; len = 10'd6; group = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        group = 4'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; group = 4'd3;
        checks++; if (err !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL busy_start_ignored got=err%b_busy%b required=err0_busy1", err, busy); end
        for (int i = 0; i < 200 && (wr_a.size() - wr0) == 0; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({src_en, src_a, dst_en, dst_we, dst_a, dst_di, busy, done, err} !== '0) begin
            failures++; $display("FAIL midrst_outputs got=%h required=0", {src_en, src_a, dst_en, dst_we, dst_a, dst_di, busy, done, err});
        end
        rst = 1'b0;
        repeat (60) @(negedge clk);
        checks++; if (wr_a.size() - wr0 != 1 || rd_q.size() - rd0 != 6 || done_cnt != done0) begin
            failures++; $display("FAIL midrst_quiet got=w%0d_r%0d_d%0d required=w1_r6_d0", wr_a.size() - wr0, rd_q.size() - rd0, done_cnt - done0);
        end
        run_job(0, 200, 6, 3, fin);
        checks++; if (dst_mem[200] !== 32'd10 || dst_mem[201] !== 32'd31) begin
            failures++; $display("FAIL midrst_rerun got=%0d,%0d required=10,31", dst_mem[200], dst_mem[201]);
        end
    endtask

    task automatic test_back_to_back();
        bit fin;
        int bad;
        for (int i = 0; i < DEPTH; i++) src_mem[i] = $urandom();
        build_expect(100, 150, 15, 5);
        @(negedge clk);
        mark();
        src_base = 9'd100; dst_base = 9'd150; len = 10'd15; group = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        fin = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (done) begin fin = 1'b1; break; end
            if (i == 20 || i == 60 || i == 100) begin
                src_base = '0; dst_base = '0; len = 10'd8; group = 4'd2; start = 1'b1;
            end else start = 1'b0;
            @(negedge clk);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (!fin || done_cnt - done0 != 1) begin failures++; $display("FAIL b2b_done got=%0d required=1", done_cnt - done0); end
        checks++; if (busy_cyc - busy0 != exp_lat || rd_q.size() - rd0 != 15) begin
            failures++; $display("FAIL b2b_activity got=busy%0d_rd%0d required=busy%0d_rd15", busy_cyc - busy0, rd_q.size() - rd0, exp_lat);
        end
        bad = (wr_a.size() - wr0 != exp_a.size()) ? 1 : 0;
        for (int k = 0; k < exp_a.size(); k++)
            if (wr0 + k >= wr_a.size() || wr_a[wr0 + k] != exp_a[k] || wr_d[wr0 + k] !== exp_d[k]) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL b2b_writes got=%0d_wrong required=0_wrong", bad); end
        run_job(7, 9, 8, 4, fin);
        checks++; if (wr_a.size() - wr0 != 2 || wr_d[wr_d.size() - 1] !== exp_d[1]) begin
            failures++; $display("FAIL b2b_next got=%0d_writes required=2_writes", wr_a.size() - wr0);
        end
    endtask

    task automatic test_random();
        bit fin;
        int sb, db, ln, g, bad;
        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < DEPTH; i++)
                src_mem[i] = (n % 3 == 0) ? 32'($urandom_range(0, 200)) - 32'd100 : $urandom();
            sb = int'($urandom_range(0, 511)); db = int'($urandom_range(0, 511));
            ln = int'($urandom_range(0, 40));  g = int'($urandom_range(1, 8));
            run_job(sb, db, ln, g, fin);
            checks++; if (!fin) begin failures++; $display("FAIL rand%0d_timeout got=no_done required=done", n); end
            bad = (wr_a.size() - wr0 != exp_a.size()) ? 1 : 0;
            for (int k = 0; k < exp_a.size(); k++)
                if (wr0 + k >= wr_a.size() || wr_a[wr0 + k] != exp_a[k] || wr_d[wr0 + k] !== exp_d[k]) bad++;
            checks++; if (bad != 0) begin failures++; $display("FAIL rand%0d_writes g=%0d len=%0d got=%0d_wrong required=0_wrong", n, g, ln, bad); end
            bad = (rd_q.size() - rd0 != exp_rd.size()) ? 1 : 0;
            for (int k = 0; k < exp_rd.size(); k++)
                if (rd0 + k >= rd_q.size() || rd_q[rd0 + k] != exp_rd[k]) bad++;
            checks++; if (bad != 0) begin failures++; $display("FAIL rand%0d_reads got=%0d_wrong required=0_wrong", n, bad); end
            checks++; if (busy_cyc - busy0 != exp_lat) begin failures++; $display("FAIL rand%0d_latency got=%0d required=%0d", n, busy_cyc - busy0, exp_lat); end
            checks++; if ((overlap - ov0) + (badwe - we0) != 0 || done_cnt - done0 != 1) begin
                failures++; $display("FAIL rand%0d_ctrl got=ov%0d_we%0d_done%0d required=ov0_we0_done1", n, overlap - ov0, badwe - we0, done_cnt - done0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_trunc();
        test_leftover();
        test_err();
        test_wrap();
        test_max();
        test_rst_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
